// File: rtl/line_setup_fifo_if.sv
// Line-setup bus: clipper-side line input plus the line-generator FIFO read port.
interface line_setup_fifo_if;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned WORD_W  = 69;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x0;
  logic [COORD_W-1:0] in_y0;
  logic [COORD_W-1:0] in_x1;
  logic [COORD_W-1:0] in_y1;
  logic [COLOR_W-1:0] in_color;
  logic               in_last;
  logic               frame_start;
  logic               fifo_rd_en;
  logic [WORD_W-1:0]  fifo_data;
  logic               fifo_empty;
  logic               end_of_objects;

  modport master (
    output in_valid, in_x0, in_y0, in_x1, in_y1, in_color, in_last,
           frame_start, fifo_rd_en,
    input  in_ready, fifo_data, fifo_empty, end_of_objects
  );

  modport slave (
    input  in_valid, in_x0, in_y0, in_x1, in_y1, in_color, in_last,
           frame_start, fifo_rd_en,
    output in_ready, fifo_data, fifo_empty, end_of_objects
  );
endinterface

// File: rtl/line_setup_fifo.sv
// Line setup: 2-stage dx/dy/octant/validity pipeline feeding a credit-controlled
// FIFO that the line generator pops with one cycle of latency.
module line_setup_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic              clk,
  input logic              rst,
  line_setup_fifo_if.slave bus
);
  localparam int unsigned COORD_W = 10;
  localparam int unsigned DELTA_W = 11;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned WORD_W  = 69;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned CRED_W  = ADDR_W + 2;
  localparam logic [COORD_W-1:0] X_MAX = 10'd639;
  localparam logic [COORD_W-1:0] Y_MAX = 10'd479;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

  slot_t s1_state, s1_next, s2_state, s2_next;
  logic  s1_occ, s2_occ;

  logic [COORD_W-1:0] s1_x0, s1_y0, s1_x1, s1_y1;
  logic [COLOR_W-1:0] s1_color;
  logic               s1_last;
  logic [DELTA_W-1:0] s1_dx, s1_dy;

  logic [WORD_W-1:0]  s2_word;
  logic               s2_last;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WORD_W-1:0]  data_q;
  logic               eoo_q;

  logic               accept, wr, pop;
  logic [CRED_W-1:0]  credits;
  logic [DELTA_W-1:0] dx_abs, dy_abs;
  logic [2:0]         octant;
  logic               on_screen;

  // Credits cover stored entries plus lines still in the pipeline.
  assign credits      = CRED_W'(count) + CRED_W'(s1_occ) + CRED_W'(s2_occ);
  assign bus.in_ready = (credits < CRED_W'(DEPTH));
  assign accept       = bus.in_valid & bus.in_ready;
  assign wr           = s2_occ;
  assign pop          = bus.fifo_rd_en & (count != '0);

  assign bus.fifo_empty     = (count == '0);
  assign bus.fifo_data      = data_q;
  assign bus.end_of_objects = eoo_q;

  // Slot occupancy state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state <= SLOT_EMPTY;
      s2_state <= SLOT_EMPTY;
    end else begin
      s1_state <= s1_next;
      s2_state <= s2_next;
    end
  end

  // Slots advance every cycle; nothing ever stalls inside the pipeline.
  always_comb begin
    s1_next = SLOT_EMPTY;
    s2_next = SLOT_EMPTY;
    if (accept)                s1_next = SLOT_FULL;
    if (s1_state == SLOT_FULL) s2_next = SLOT_FULL;
  end

  always_comb begin
    s1_occ = 1'b0;
    s2_occ = 1'b0;
    if (s1_state == SLOT_FULL) s1_occ = 1'b1;
    if (s2_state == SLOT_FULL) s2_occ = 1'b1;
  end

  // S1: capture the line and form signed deltas from zero-extended coordinates.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x0    <= bus.in_x0;
      s1_y0    <= bus.in_y0;
      s1_x1    <= bus.in_x1;
      s1_y1    <= bus.in_y1;
      s1_color <= bus.in_color;
      s1_last  <= bus.in_last;
      s1_dx    <= DELTA_W'({1'b0, bus.in_x1}) - DELTA_W'({1'b0, bus.in_x0});
      s1_dy    <= DELTA_W'({1'b0, bus.in_y1}) - DELTA_W'({1'b0, bus.in_y0});
    end
  end

  always_comb begin
    dx_abs    = s1_dx[DELTA_W-1] ? DELTA_W'(-s1_dx) : s1_dx;
    dy_abs    = s1_dy[DELTA_W-1] ? DELTA_W'(-s1_dy) : s1_dy;
    octant    = {s1_dy[DELTA_W-1], s1_dx[DELTA_W-1], (dy_abs > dx_abs)};
    on_screen = (s1_x0 <= X_MAX) && (s1_x1 <= X_MAX) &&
                (s1_y0 <= Y_MAX) && (s1_y1 <= Y_MAX);
  end

  // S2: pack the line word; off-screen lines are still queued with valid clear.
  always_ff @(posedge clk) begin
    if (s1_occ) begin
      s2_word <= {s1_x0, s1_y0, s1_x1, s1_y1, s1_dy, s1_dx,
                  s1_color, on_screen, octant};
      s2_last <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s2_word;
  end

  // Pointers, occupancy count, read data register and frame-done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
      eoo_q  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        data_q <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr && s2_last)         eoo_q <= 1'b1;
      else if (bus.frame_start)  eoo_q <= 1'b0;
    end
  end
endmodule
